// File: rtl/hyperspace_pin_stream_bridge.sv
// Pad-level byte-stream to 16-bit word-stream bridge: packs byte pairs into
// words, buffers them in a first-word-fall-through FIFO and drives the pads.
module hyperspace_pin_stream_bridge #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [0:0] PH_LOW  = 1'b0;
    localparam logic [0:0] PH_HIGH = 1'b1;

    localparam logic [37:0] OEB_C = 38'h3F_F7FC_0000;

    logic        w_out_ready;
    logic        w_in_valid;
    logic        w_in_last;
    logic [7:0]  w_in_data;
    logic        w_unused_pins;

    logic [15:0] r_mem_data [FIFO_DEPTH];
    logic        r_mem_last [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [0:0]    r_phase;
    logic [7:0]    r_low_byte;
    logic          r_in_ready;

    logic          w_accept;
    logic          w_pop;
    logic          w_out_valid;
    logic          w_push;
    logic          w_wr_en;
    logic [15:0]   w_push_data;
    logic          w_push_last;
    logic [0:0]    w_phase_next;
    logic [7:0]    w_low_next;
    logic [CW-1:0] w_count_next;

    assign w_out_ready   = io_in[18];
    assign w_in_valid    = io_in[28];
    assign w_in_last     = io_in[29];
    assign w_unused_pins = &{io_in[17:0], io_in[27:19]};

    // Data pins are wired MSB-first: io_in[30] carries bit 7.
    always_comb begin
        w_in_data = '0;
        for (int i = 0; i < 8; i++) begin
            w_in_data[i] = io_in[37-i];
        end
    end

    assign w_out_valid = (r_count != '0);
    assign w_accept    = w_in_valid && r_in_ready;
    assign w_pop       = w_out_valid && w_out_ready;

    always_comb begin
        w_phase_next = r_phase;
        w_low_next   = r_low_byte;
        w_push       = 1'b0;
        w_push_data  = '0;
        w_push_last  = 1'b0;
        if (w_accept) begin
            case (r_phase)
                PH_LOW: begin
                    if (w_in_last) begin
                        w_push      = 1'b1;
                        w_push_data = {8'h00, w_in_data};
                        w_push_last = 1'b1;
                    end else begin
                        w_low_next   = w_in_data;
                        w_phase_next = PH_HIGH;
                    end
                end
                default: begin
                    w_push       = 1'b1;
                    w_push_data  = {w_in_data, r_low_byte};
                    w_push_last  = w_in_last;
                    w_phase_next = PH_LOW;
                end
            endcase
        end
    end

    // A write into a full buffer is only safe when the head leaves on the same edge.
    assign w_wr_en = w_push && ((r_count != DEPTH_C) || w_pop);

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_en, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_phase    <= PH_LOW;
            r_low_byte <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_phase    <= w_phase_next;
            r_low_byte <= w_low_next;
            r_in_ready <= (w_count_next < DEPTH_C);
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_last[r_wr_ptr] <= w_push_last;
        end
    end

    // Head fields are gated by valid so the pads read zero in reset and when empty.
    always_comb begin
        io_out        = '0;
        io_out[15:0]  = w_out_valid ? r_mem_data[r_rd_ptr] : 16'h0000;
        io_out[16]    = w_out_valid && r_mem_last[r_rd_ptr];
        io_out[17]    = w_out_valid;
        io_out[27]    = r_in_ready;
    end

    assign io_oeb = OEB_C;

endmodule

// File: tb/tb_hyperspace_pin_stream_bridge.sv
// Directed bench for hyperspace_pin_stream_bridge: byte source queue, expected
// word queue, occupancy model and immediate-assertion checks.
module tb_hyperspace_pin_stream_bridge;

  localparam int FIFO_DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetb;
  logic [37:0] io_in;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  logic        out_ready_d;
  logic        in_valid_d;
  logic        in_last_d;
  logic [7:0]  in_data_d;

  int total = 0;
  int bad = 0;
  int m_cnt = 0;
  logic m_phase = 1'b0;
  int n_pop = 0;
  int cyc;

  logic [8:0]  src_q[$];
  logic [16:0] exp_q[$];

  always #5 clock = ~clock;

  always_comb begin
    io_in = '0;
    io_in[18] = out_ready_d;
    io_in[28] = in_valid_d;
    io_in[29] = in_last_d;
    for (int i = 0; i < 8; i++) begin
      io_in[37-i] = in_data_d[i];
    end
  end

  hyperspace_pin_stream_bridge #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock  (clock),
    .resetb (resetb),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  wire [15:0] w_out_data  = io_out[15:0];
  wire        w_out_last  = io_out[16];
  wire        w_out_valid = io_out[17];
  wire        w_in_ready  = io_out[27];

  task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    if (src_q.size() != 0) begin
      in_valid_d = 1'b1;
      in_last_d  = src_q[0][8];
      in_data_d  = src_q[0][7:0];
    end else begin
      in_valid_d = 1'b0;
      in_last_d  = 1'b0;
      in_data_d  = 8'h00;
    end
  endtask

  // One clock: predict handshakes from pre-edge pins, then check post-edge pins.
  task automatic cycle();
    logic acc;
    logic pop;
    logic stall;
    logic [16:0] word;
    logic [8:0] b;
    acc   = in_valid_d && w_in_ready;
    pop   = w_out_valid && out_ready_d;
    stall = w_out_valid && !out_ready_d;
    word  = {w_out_last, w_out_data};
    @(posedge clock);
    #1;
    if (acc) begin
      b = src_q.pop_front();
      if (m_phase) begin
        m_phase = 1'b0;
        m_cnt++;
      end else if (b[8]) begin
        m_cnt++;
      end else begin
        m_phase = 1'b1;
      end
    end
    if (pop) begin
      m_cnt--;
      n_pop++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL extra_word: observed=%h expected=none", word);
      end
      if (exp_q.size() != 0) begin
        check("word", {21'd0, word}, {21'd0, exp_q.pop_front()});
      end
    end
    check("in_ready", {37'd0, w_in_ready}, {37'd0, (m_cnt < FIFO_DEPTH)});
    check("out_valid", {37'd0, w_out_valid}, {37'd0, (m_cnt != 0)});
    if (stall) begin
      check("hold_word", {21'd0, w_out_last, w_out_data}, {21'd0, word});
    end
    drive_src();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 38'(src_q.size() + exp_q.size()), 38'd0);
  endtask

  initial begin
    resetb      = 1'b0;
    out_ready_d = 1'b0;
    in_valid_d  = 1'b0;
    in_last_d   = 1'b0;
    in_data_d   = 8'h00;

    // Reset
    repeat (2) @(posedge clock);
    #1;
    check("reset_io_out", io_out, 38'd0);
    check("reset_io_oeb", io_oeb, 38'h3F_F7FC_0000);
    check("reset_in_ready", {37'd0, w_in_ready}, 38'd0);
    resetb = 1'b1;
    @(posedge clock);
    #1;
    check("release_in_ready", {37'd0, w_in_ready}, 38'd1);
    check("release_out_valid", {37'd0, w_out_valid}, 38'd0);
    check("release_io_oeb", io_oeb, 38'h3F_F7FC_0000);

    // Basic packing
    out_ready_d = 1'b1;
    n_pop = 0;
    src_q.push_back(9'h034);
    src_q.push_back(9'h012);
    exp_q.push_back(17'h0_1234);
    drive_src();
    cycle();
    check("basic_first_byte_no_word", {37'd0, w_out_valid}, 38'd0);
    cycle();
    check("basic_valid", {37'd0, w_out_valid}, 38'd1);
    check("basic_data", {22'd0, w_out_data}, {22'd0, 16'h1234});
    check("basic_last", {37'd0, w_out_last}, 38'd0);
    cycle();
    check("basic_pops", 38'(n_pop), 38'd1);
    check("basic_drained", {37'd0, w_out_valid}, 38'd0);

    // Odd last byte, then phase must be back in LOW
    n_pop = 0;
    src_q.push_back(9'h1AB);
    src_q.push_back(9'h001);
    src_q.push_back(9'h002);
    exp_q.push_back(17'h1_00AB);
    exp_q.push_back(17'h0_0201);
    drive_src();
    cycle();
    check("odd_word", {21'd0, w_out_last, w_out_data}, {21'd0, 17'h1_00AB});
    cycle();
    cycle();
    check("odd_next_pair", {21'd0, w_out_last, w_out_data}, {21'd0, 17'h0_0201});
    cycle();
    check("odd_pops", 38'(n_pop), 38'd2);

    // Backpressure until full, then drain in order
    out_ready_d = 1'b0;
    n_pop = 0;
    for (int b = 0; b < 2 * FIFO_DEPTH + 4; b++) begin
      src_q.push_back({1'b0, 8'(b)});
    end
    for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
      exp_q.push_back({1'b0, 8'(2 * k + 1), 8'(2 * k)});
    end
    drive_src();
    repeat (24) cycle();
    check("bp_left_in_source", 38'(src_q.size()), 38'd4);
    check("bp_in_ready_low", {37'd0, w_in_ready}, 38'd0);
    check("bp_head_data", {22'd0, w_out_data}, {22'd0, 16'h0100});
    out_ready_d = 1'b1;
    run_until_idle("bp_drain_idle", 100);
    check("bp_pops", 38'(n_pop), 38'd10);

    // Simultaneous push/pop starting from full
    out_ready_d = 1'b0;
    n_pop = 0;
    for (int b = 0; b < 40; b++) begin
      src_q.push_back({1'b0, 8'(8'h40 + b)});
    end
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back({1'b0, 8'(8'h40 + 2 * k + 1), 8'(8'h40 + 2 * k)});
    end
    drive_src();
    repeat (20) cycle();
    check("pp_full_in_ready", {37'd0, w_in_ready}, 38'd0);
    check("pp_full_left", 38'(src_q.size()), 38'd24);
    out_ready_d = 1'b1;
    cyc = 0;
    while (src_q.size() != 0 && cyc < 100) begin
      cycle();
      cyc++;
    end
    check("pp_accept_cycles", 38'(cyc), 38'd25);
    run_until_idle("pp_drain_idle", 100);
    check("pp_pops", 38'(n_pop), 38'd20);

    // Long frame with random output backpressure
    n_pop = 0;
    for (int i = 0; i < 2048; i++) begin
      src_q.push_back({(i == 2047), 8'(i)});
    end
    for (int k = 0; k < 1024; k++) begin
      exp_q.push_back({(k == 1023), 8'(2 * k + 1), 8'(2 * k)});
    end
    drive_src();
    cyc = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < 20000) begin
      out_ready_d = ($urandom_range(0, 3) != 0);
      cycle();
      cyc++;
    end
    check("frame_idle", 38'(src_q.size() + exp_q.size()), 38'd0);
    check("frame_pops", 38'(n_pop), 38'd1024);

    // Mid-frame asynchronous reset with 3 words and an odd byte held
    out_ready_d = 1'b0;
    for (int b = 0; b < 7; b++) begin
      src_q.push_back({1'b0, 8'(8'hA0 + b)});
    end
    drive_src();
    repeat (10) cycle();
    check("mr_source_taken", 38'(src_q.size()), 38'd0);
    check("mr_buffered_valid", {37'd0, w_out_valid}, 38'd1);
    #1;
    resetb = 1'b0;
    #1;
    check("mr_valid_falls", {37'd0, w_out_valid}, 38'd0);
    check("mr_io_out_zero", io_out, 38'd0);
    m_cnt = 0;
    m_phase = 1'b0;
    exp_q.delete();
    @(posedge clock);
    #1;
    check("mr_in_ready_in_reset", {37'd0, w_in_ready}, 38'd0);
    resetb = 1'b1;
    @(posedge clock);
    #1;
    check("mr_in_ready_release", {37'd0, w_in_ready}, 38'd1);
    check("mr_no_stale", {37'd0, w_out_valid}, 38'd0);
    out_ready_d = 1'b1;
    n_pop = 0;
    src_q.push_back(9'h055);
    src_q.push_back(9'h066);
    exp_q.push_back(17'h0_6655);
    drive_src();
    run_until_idle("mr_idle", 50);
    repeat (4) cycle();
    check("mr_pops", 38'(n_pop), 38'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
